// File: rtl/user_rw_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : user_reg_pkg
// Description : Shared constants and helpers for the JTAG user-register bank.
//               onehot() qualifies a function-select vector, idx() returns the
//               position of its set bit, CNT_W sizes the shift-length counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package user_reg_pkg;

    localparam int MAX_NREG  = 16;
    localparam int MAX_WIDTH = 64;

    // Wide enough to hold any legal register width, so the counter can
    // saturate at WIDTH without wrapping.
    localparam int CNT_W = $clog2(MAX_WIDTH + 1);

    // True when exactly one bit of v is set.
    function automatic bit onehot(input logic [MAX_NREG-1:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction

    // Index of the set bit of a one-hot vector.
    function automatic logic [3:0] idx(input logic [MAX_NREG-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < MAX_NREG; i++) begin
            if (v[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/user_rw_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : user_rw_reg_bank_if
// Description : BSCAN-side user port of the register bank.
//               master : TAP / host side, drives the JTAG lines and RB_IN.
//               slave  : register bank, drives TDO, PO, UPD_STB and ERR.
// Signals     : DRCK, SEL, FSEL[NREG], CAPTURE, SHIFT, UPDATE, TDI,
//               RB_IN[NREG*WIDTH], TDO, PO[NREG*WIDTH], UPD_STB[NREG], ERR
// Revision    : 1.0 - initial release
// ============================================================================
interface user_rw_reg_bank_if #(
    parameter int NREG  = 4,
    parameter int WIDTH = 16
);
    logic                  DRCK;
    logic                  SEL;
    logic [NREG-1:0]       FSEL;
    logic                  CAPTURE;
    logic                  SHIFT;
    logic                  UPDATE;
    logic                  TDI;
    logic [NREG*WIDTH-1:0] RB_IN;
    logic                  TDO;
    logic [NREG*WIDTH-1:0] PO;
    logic [NREG-1:0]       UPD_STB;
    logic                  ERR;

    modport master (
        output DRCK, SEL, FSEL, CAPTURE, SHIFT, UPDATE, TDI, RB_IN,
        input  TDO, PO, UPD_STB, ERR
    );

    modport slave (
        input  DRCK, SEL, FSEL, CAPTURE, SHIFT, UPDATE, TDI, RB_IN,
        output TDO, PO, UPD_STB, ERR
    );
endinterface
`default_nettype wire

// File: rtl/user_rw_reg_bank_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : jtag_sync_edge
// Description : W-bit two-flop synchroniser. With EDGE=0 the output is the
//               synchronised level; with EDGE=1 a third flop delays the
//               synchronised level and the output is a one-cycle pulse on
//               each rising transition.
// Ports       : clk   - fabric clock
//               rst_n - synchronous active-low reset (clears every flop)
//               i_d   - asynchronous inputs
//               o_y   - synchronised level or rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_sync_edge #(
    parameter int W    = 1,
    parameter bit EDGE = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [W-1:0] i_d,
    output logic      [W-1:0] o_y
);
    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic [W-1:0] dly_q, dly_d;

            always_comb dly_d = sync_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign o_y = sync_q & ~dly_q;
        end else begin : g_level
            assign o_y = sync_q;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/user_rw_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : user_rw_reg_bank
// Description : JTAG user-register bank. NREG registers of WIDTH bits share
//               one shift register; FSEL picks the target. All JTAG lines are
//               resynchronised into CLK25, so PO, UPD_STB, ERR and TDO are
//               fully synchronous to the fabric clock.
// Ports       : CLK25 - fabric clock
//               RST_N - synchronous active-low reset
//               bus   - slave side of user_rw_reg_bank_if (JTAG lines in,
//                       RB_IN in, TDO / PO / UPD_STB / ERR out)
// Revision    : 1.0 - initial release
// ============================================================================
module user_rw_reg_bank
    import user_reg_pkg::*;
#(
    parameter int                    NREG      = 4,
    parameter int                    WIDTH     = 16,
    parameter logic [NREG*WIDTH-1:0] DEF_VALUE = '0,
    parameter bit                    RB_EXT    = 1'b0
) (
    input  wire logic          CLK25,
    input  wire logic          RST_N,
    user_rw_reg_bank_if.slave  bus
);
    localparam int               IDX_W    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    // ------------------------------------------------------------------
    // Resynchronisation
    // ------------------------------------------------------------------
    logic [1:0]      edge_y;
    logic [NREG+3:0] lvl_y;
    logic            drck_rise, upd_rise;
    logic            sel_s, cap_s, shift_s, tdi_s;
    logic [NREG-1:0] fsel_s;

    jtag_sync_edge #(.W(2), .EDGE(1'b1)) u_sync_edge (
        .clk   (CLK25),
        .rst_n (RST_N),
        .i_d   ({bus.DRCK, bus.UPDATE}),
        .o_y   (edge_y)
    );

    jtag_sync_edge #(.W(NREG + 4), .EDGE(1'b0)) u_sync_lvl (
        .clk   (CLK25),
        .rst_n (RST_N),
        .i_d   ({bus.SEL, bus.CAPTURE, bus.SHIFT, bus.TDI, bus.FSEL}),
        .o_y   (lvl_y)
    );

    assign {drck_rise, upd_rise}                  = edge_y;
    assign {sel_s, cap_s, shift_s, tdi_s, fsel_s} = lvl_y;

    // ------------------------------------------------------------------
    // Selection decode
    // ------------------------------------------------------------------
    logic [MAX_NREG-1:0] fsel_ext;
    logic                valid;
    logic [IDX_W-1:0]    k;

    assign fsel_ext = MAX_NREG'(fsel_s);
    assign valid    = sel_s & onehot(fsel_ext);
    assign k        = IDX_W'(idx(fsel_ext));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] po_q [NREG];
    logic [WIDTH-1:0] po_d [NREG];
    logic [WIDTH-1:0] cap_val [NREG];
    logic             pend_q, pend_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [WIDTH-1:0] pend_data_q, pend_data_d;
    logic [NREG-1:0]  stb_q, stb_d;
    logic             err_q, err_d;
    logic             tdo_q, tdo_d;

    generate
        if (RB_EXT) begin : g_rb_ext
            for (genvar i = 0; i < NREG; i++) begin : g_slice
                assign cap_val[i] = bus.RB_IN[i*WIDTH +: WIDTH];
            end
        end else begin : g_rb_po
            for (genvar i = 0; i < NREG; i++) begin : g_slice
                assign cap_val[i] = po_q[i];
            end
        end
    endgenerate

    always_comb begin
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        po_d        = po_q;
        pend_d      = 1'b0;
        pend_idx_d  = pend_idx_q;
        pend_data_d = pend_data_q;
        stb_d       = '0;
        err_d       = err_q;
        tdo_d       = valid & sh_q[0];

        // Commit stage: one cycle after the update edge, so PO and the
        // strobe move together and the committed data was sampled before
        // any coincident shift.
        if (pend_q) begin
            po_d[pend_idx_q]  = pend_data_q;
            stb_d[pend_idx_q] = 1'b1;
        end

        if (drck_rise && valid) begin
            if (cap_s) begin
                sh_d  = cap_val[k];
                cnt_d = '0;
                err_d = 1'b0;
            end else if (shift_s) begin
                sh_d = {tdi_s, sh_q[WIDTH-1:1]};
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // An update with SEL low is not addressed to this bank at all.
        if (upd_rise && sel_s) begin
            if (valid && (cnt_q == CNT_FULL)) begin
                pend_d      = 1'b1;
                pend_idx_d  = k;
                pend_data_d = sh_q;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK25) begin
        if (!RST_N) begin
            sh_q        <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            pend_data_q <= '0;
            stb_q       <= '0;
            err_q       <= 1'b0;
            tdo_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                po_q[i] <= DEF_VALUE[i*WIDTH +: WIDTH];
            end
        end else begin
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            pend_data_q <= pend_data_d;
            stb_q       <= stb_d;
            err_q       <= err_d;
            tdo_q       <= tdo_d;
            po_q        <= po_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NREG; i++) begin : g_po
            assign bus.PO[i*WIDTH +: WIDTH] = po_q[i];
        end
    endgenerate

    assign bus.TDO     = tdo_q;
    assign bus.UPD_STB = stb_q;
    assign bus.ERR     = err_q;
endmodule
`default_nettype wire
